// File: rtl/rvbus_pkg.sv
// Shared types for the RV32 core-bus arbiter family: request bundle, pipeline
// entry carrying a read tag, and master-count limits.
package rvbus_pkg;

  localparam int RVBUS_MAX_MASTERS = 8;
  localparam int RVBUS_IDX_W       = $clog2(RVBUS_MAX_MASTERS);
  localparam int RVBUS_ADDR_W      = 32;
  localparam int RVBUS_DATA_W      = 32;
  localparam int RVBUS_BE_W        = RVBUS_DATA_W / 8;

  typedef struct packed {
    logic                    we;
    logic [RVBUS_ADDR_W-1:0] addr;
    logic [RVBUS_DATA_W-1:0] wdata;
    logic [RVBUS_BE_W-1:0]   be;
  } rvbus_req_t;

  typedef struct packed {
    logic                   valid;
    logic [RVBUS_IDX_W-1:0] idx;
  } rvbus_pipe_t;

endpackage

// File: rtl/rvbus_rr_picker.sv
// Combinational round-robin picker: searches last+1, last+2, ... with wrap and
// returns a one-hot grant plus the winning index.
module rvbus_rr_picker
  import rvbus_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             req_i,
  input  logic [RVBUS_IDX_W-1:0]   last_i,
  output logic [N-1:0]             gnt_o,
  output logic [RVBUS_IDX_W-1:0]   idx_o,
  output logic                     any_o
);

  // Two passes give the wrapped order: indices above last first, then 0..last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (RVBUS_IDX_W'(i) > last_i)) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = RVBUS_IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (RVBUS_IDX_W'(i) <= last_i)) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = RVBUS_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rvbus_arbiter.sv
// N-master round-robin arbiter onto one fixed-latency memory port with tagged
// read return. Optional grant locking is enabled by defining RVBUS_ARB_LOCK_EN.
module rvbus_arbiter
  import rvbus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_MASTERS-1:0]                m_req,
  input  logic [NUM_MASTERS-1:0]                m_we,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]    m_addr,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]  m_be,
`ifdef RVBUS_ARB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]                m_lock,
`endif
  output logic [NUM_MASTERS-1:0]                m_gnt,
  output logic [NUM_MASTERS-1:0]                m_rvalid,
  output logic [DATA_W-1:0]                     m_rdata,
  output logic                                  mem_en,
  output logic [DATA_W/8-1:0]                   mem_wea,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [DATA_W-1:0]                     mem_din,
  input  logic [DATA_W-1:0]                     mem_dout
);

  logic [RVBUS_IDX_W-1:0] last_q, last_d;
  logic [NUM_MASTERS-1:0] rr_gnt, gnt;
  logic [RVBUS_IDX_W-1:0] rr_idx, gidx;
  logic                   rr_any, any_gnt, sel_we;
  rvbus_pipe_t            entry_d;
  rvbus_pipe_t            pipe_q [MEM_LATENCY];
  rvbus_pipe_t            pipe_out;

  rvbus_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req_i  (m_req),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  // Grant resolution; a locked holder overrides round-robin, reset masks all.
  always_comb begin
    gnt     = rr_gnt;
    gidx    = rr_idx;
    any_gnt = rr_any;
`ifdef RVBUS_ARB_LOCK_EN
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((RVBUS_IDX_W'(i) == last_q) && m_lock[i] && m_req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gidx    = last_q;
        any_gnt = 1'b1;
      end
    end
`endif
    if (rst) begin
      gnt     = '0;
      gidx    = last_q;
      any_gnt = 1'b0;
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_wea  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        mem_addr = m_addr[i];
        mem_din  = m_wdata[i];
        mem_wea  = m_we[i] ? m_be[i] : '0;
        sel_we   = m_we[i];
      end
    end
  end

  assign m_gnt         = gnt;
  assign mem_en        = any_gnt;
  assign last_d        = any_gnt ? gidx : last_q;
  assign entry_d.valid = any_gnt && !sel_we;
  assign entry_d.idx   = gidx;

  // Stage boundary: read tags shift one slot per cycle toward the return port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= RVBUS_IDX_W'(NUM_MASTERS - 1);
      for (int i = 0; i < MEM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      last_q    <= last_d;
      pipe_q[0] <= entry_d;
      for (int i = 1; i < MEM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out = pipe_q[MEM_LATENCY-1];

  always_comb begin
    m_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (pipe_out.valid && (pipe_out.idx == RVBUS_IDX_W'(i))) m_rvalid[i] = 1'b1;
    end
  end

  assign m_rdata = pipe_out.valid ? mem_dout : '0;

endmodule

// File: tb/tb_rvbus_arbiter.sv
// Directed bench for rvbus_arbiter with four masters and a two-cycle memory.
module tb_rvbus_arbiter;

  localparam int NM  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM-1:0]          m_req = '0;
  logic [NM-1:0]          m_we = '0;
  logic [NM-1:0][AW-1:0]  m_addr = '0;
  logic [NM-1:0][DW-1:0]  m_wdata = '0;
  logic [NM-1:0][BW-1:0]  m_be = '0;
`ifdef RVBUS_ARB_LOCK_EN
  logic [NM-1:0]          m_lock = '0;
`endif
  logic [NM-1:0]          m_gnt, m_rvalid;
  logic [DW-1:0]          m_rdata, mem_din, mem_dout;
  logic                   mem_en;
  logic [BW-1:0]          mem_wea;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          d1, d2;

  int n_assert = 0;
  int n_fail   = 0;

  rvbus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
`ifdef RVBUS_ARB_LOCK_EN
    .m_lock   (m_lock),
`endif
    .m_gnt    (m_gnt),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .mem_en   (mem_en),
    .mem_wea  (mem_wea),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5AA5A5;
  endfunction

  // Two-cycle synchronous memory model: data for an access at T appears at T+2.
  always_ff @(posedge clk) begin
    d1 <= mem_en ? mem_f(mem_addr) : 32'h0;
    d2 <= d1;
  end
  assign mem_dout = d2;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      m_req = '0;
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1; m_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    m_req = 4'b1111; m_we = 4'b0101; m_addr[0] = 32'h44; m_wdata[0] = 32'hCAFE0000; m_be[0] = 4'hF;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b expected %b", m_gnt, 4'b0000); end
    n_assert++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    n_assert++; if (mem_addr !== 32'h0 || mem_din !== 32'h0 || mem_wea !== 4'h0) begin n_fail++; $display("FAIL reset_mem_bus: got addr %h din %h wea %b expected zeros", mem_addr, mem_din, mem_wea); end
    n_assert++; if (m_rvalid !== 4'b0000 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rvalid: got %b/%h expected 0/0", m_rvalid, m_rdata); end
    @(posedge clk); #1;
    rst = 1'b0; m_req = 4'b1001; m_we = '0;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_prio: got %b expected %b", m_gnt, 4'b0001); end
    idle(3);
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    m_req = 4'b0010; m_we = '0; m_addr[1] = 32'h100;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b expected %b", m_gnt, 4'b0010); end
    n_assert++; if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_wea !== 4'h0) begin n_fail++; $display("FAIL single_mem: got en %b addr %h wea %b expected 1/100/0", mem_en, mem_addr, mem_wea); end
    @(posedge clk); #1;
    m_req = '0;
    @(negedge clk);
    n_assert++; if (m_rvalid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b expected %b", m_rvalid, 4'b0000); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if (m_rvalid !== 4'b0010) begin n_fail++; $display("FAIL single_rvalid: got %b expected %b", m_rvalid, 4'b0010); end
    n_assert++; if (m_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", m_rdata, 32'hDEADBEEF); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if (m_rvalid !== 4'b0000 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL single_after: got %b/%h expected 0/0", m_rvalid, m_rdata); end
  endtask

  task automatic test_contention();
    logic [31:0] exp_a [10];
    logic [3:0]  exp_g, exp_v;
    int n0 = 0;
    int n1 = 0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      m_we = '0;
      m_addr[0] = 32'h1000 + n0 * 4;
      m_addr[1] = 32'h2000 + n1 * 4;
      m_req = (c < 8) ? 4'b0011 : 4'b0000;
      @(negedge clk);
      if (c < 8) begin
        exp_g = 4'b0001 << (c % 2);
        n_assert++; if (m_gnt !== exp_g) begin n_fail++; $display("FAIL contention_gnt c%0d: got %b expected %b", c, m_gnt, exp_g); end
        exp_a[c] = (c % 2 == 0) ? m_addr[0] : m_addr[1];
        if (c % 2 == 0) n0++; else n1++;
      end
      if (c >= 2) begin
        exp_v = 4'b0001 << ((c - 2) % 2);
        n_assert++; if (m_rvalid !== exp_v) begin n_fail++; $display("FAIL contention_rvalid c%0d: got %b expected %b", c, m_rvalid, exp_v); end
        n_assert++; if (m_rdata !== mem_f(exp_a[c-2])) begin n_fail++; $display("FAIL contention_rdata c%0d: got %h expected %h", c, m_rdata, mem_f(exp_a[c-2])); end
      end
    end
  endtask

  task automatic test_byte_write();
    @(posedge clk); #1;
    m_req = 4'b0100; m_we = '0; m_addr[2] = 32'h300;
    m_wdata[1] = 32'hFFFF0000; m_be[1] = 4'hF;
    idle(1);
    @(posedge clk); #1;
    m_req = 4'b0001; m_we = 4'b0001; m_addr[0] = 32'h40; m_wdata[0] = 32'h11223344; m_be[0] = 4'b0101;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0001 || mem_en !== 1'b1) begin n_fail++; $display("FAIL write_gnt: got %b/%b expected 0001/1", m_gnt, mem_en); end
    n_assert++; if (mem_wea !== 4'b0101) begin n_fail++; $display("FAIL write_wea: got %b expected %b", mem_wea, 4'b0101); end
    n_assert++; if (mem_din !== 32'h11223344 || mem_addr !== 32'h40) begin n_fail++; $display("FAIL write_din: got %h@%h expected 11223344@40", mem_din, mem_addr); end
    n_assert++; if (m_rvalid !== 4'b0100 || m_rdata !== mem_f(32'h300)) begin n_fail++; $display("FAIL write_overlap_read: got %b/%h expected 0100/%h", m_rvalid, m_rdata, mem_f(32'h300)); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      m_req = '0; m_we = '0;
      @(negedge clk);
      n_assert++; if (m_rvalid !== 4'b0000 || m_rdata !== 32'h0) begin n_fail++; $display("FAIL write_no_rvalid c%0d: got %b/%h expected 0/0", c, m_rvalid, m_rdata); end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    m_req = 4'b0001; m_we = '0; m_addr[0] = 32'h500;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_issue: got %b expected %b", m_gnt, 4'b0001); end
    @(posedge clk); #1;
    rst = 1'b1; m_req = 4'b0010; m_addr[1] = 32'h600;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0000 || mem_en !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt: got %b/%b expected 0000/0", m_gnt, mem_en); end
    @(posedge clk); #1;
    @(negedge clk);
    n_assert++; if (m_rvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rvalid_in_rst: got %b expected %b", m_rvalid, 4'b0000); end
    @(posedge clk); #1;
    rst = 1'b0; m_req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_assert++; if (m_rvalid !== 4'b0000) begin n_fail++; $display("FAIL midrst_rvalid c%0d: got %b expected %b", c, m_rvalid, 4'b0000); end
      @(posedge clk); #1;
    end
    m_req = 4'b0011;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_first_gnt: got %b expected %b", m_gnt, 4'b0001); end
    idle(3);
  endtask

`ifdef RVBUS_ARB_LOCK_EN
  task automatic test_lock();
    @(posedge clk); #1;
    m_req = 4'b0010; m_we = '0; m_lock = '0;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_prime: got %b expected %b", m_gnt, 4'b0010); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      m_req = 4'b0011; m_lock = 4'b0010;
      @(negedge clk);
      n_assert++; if (m_gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_hold c%0d: got %b expected %b", c, m_gnt, 4'b0010); end
    end
    @(posedge clk); #1;
    m_lock = '0;
    @(negedge clk);
    n_assert++; if (m_gnt !== 4'b0001) begin n_fail++; $display("FAIL lock_release: got %b expected %b", m_gnt, 4'b0001); end
    idle(3);
  endtask
`endif

  task automatic test_back_to_back();
    logic [3:0]  pend, exp_g, exp_v;
    int          last_m, gi, j;
    int          waitc [4];
    logic        iss_v [4];
    int          iss_m [4];
    logic [31:0] iss_a [4];
    logic [31:0] exp_d;
    apply_reset();
    pend = '0; last_m = NM - 1;
    for (int i = 0; i < 4; i++) begin waitc[i] = 0; iss_v[i] = 1'b0; iss_m[i] = 0; iss_a[i] = '0; end
    for (int c = 0; c < 1002; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NM; i++) begin
        if (!pend[i] && c < 1000 && $urandom_range(0, 3) != 0) begin
          pend[i]    = 1'b1;
          m_we[i]    = 1'($urandom_range(0, 1));
          m_addr[i]  = $urandom & 32'hFFFF_FFFC;
          m_wdata[i] = $urandom;
          m_be[i]    = 4'($urandom_range(0, 15));
        end
      end
      m_req = pend;
      @(negedge clk);
      exp_g = '0; gi = -1;
      for (int k = 1; k <= NM; k++) begin
        j = (last_m + k) % NM;
        if (gi < 0 && pend[j]) begin exp_g[j] = 1'b1; gi = j; end
      end
      n_assert++; if (m_gnt !== exp_g) begin n_fail++; $display("FAIL b2b_gnt c%0d: got %b expected %b", c, m_gnt, exp_g); end
      exp_v = iss_v[(c+2)%4] ? (4'b0001 << iss_m[(c+2)%4]) : 4'b0000;
      exp_d = iss_v[(c+2)%4] ? mem_f(iss_a[(c+2)%4]) : 32'h0;
      n_assert++; if (m_rvalid !== exp_v || m_rdata !== exp_d) begin n_fail++; $display("FAIL b2b_return c%0d: got %b/%h expected %b/%h", c, m_rvalid, m_rdata, exp_v, exp_d); end
      iss_v[c%4] = 1'b0;
      if (gi >= 0) begin
        n_assert++; if (mem_addr !== m_addr[gi] || mem_wea !== (m_we[gi] ? m_be[gi] : 4'h0)) begin n_fail++; $display("FAIL b2b_mux c%0d: got %h/%b expected %h/%b", c, mem_addr, mem_wea, m_addr[gi], m_we[gi] ? m_be[gi] : 4'h0); end
        n_assert++; if (waitc[gi] > NM - 1) begin n_fail++; $display("FAIL b2b_starve m%0d: got %0d expected <= %0d", gi, waitc[gi], NM - 1); end
        for (int i = 0; i < NM; i++) if (pend[i] && i != gi) waitc[i]++;
        waitc[gi] = 0;
        iss_v[c%4] = !m_we[gi]; iss_m[c%4] = gi; iss_a[c%4] = m_addr[gi];
        last_m = gi; pend[gi] = 1'b0;
      end
    end
    idle(2);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_reset_midflight();
`ifdef RVBUS_ARB_LOCK_EN
    test_lock();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
